// File: rtl/sm_irq_ctrl.sv
// External interrupt controller driving the CP0 hardware interrupt input (cp0_ExcIP2).
// Define SM_CONFIG_IRQ_SYNC_EN to add a 2-flop synchronizer on every irq_in line.
module sm_irq_ctrl #(
  parameter int unsigned IRQ_NUM = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_in,
  input  logic [1:0]         reg_addr,
  input  logic               reg_we,
  input  logic [31:0]        reg_wd,
  output logic [31:0]        reg_rd,
  output logic               irq_req
);

  localparam logic [1:0] AddrPending = 2'd0;
  localparam logic [1:0] AddrMask    = 2'd1;
  localparam logic [1:0] AddrMode    = 2'd2;
  localparam logic [1:0] AddrId      = 2'd3;

  logic [IRQ_NUM-1:0] lineSmp;
  logic [IRQ_NUM-1:0] histQ;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] w1c;
  logic [IRQ_NUM-1:0] pendingQ, pendingD;
  logic [IRQ_NUM-1:0] maskQ;
  logic [IRQ_NUM-1:0] modeQ;
  logic [IRQ_NUM-1:0] active;
  logic               anyActive;
  logic [4:0]         idIdx;
  logic               unusedWdBits;

`ifdef SM_CONFIG_IRQ_SYNC_EN
  logic [IRQ_NUM-1:0] sync1Q, sync2Q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1Q <= '0;
      sync2Q <= '0;
    end else begin
      sync1Q <= irq_in;
      sync2Q <= sync1Q;
    end
  end

  assign lineSmp = sync2Q;
`else
  assign lineSmp = irq_in;
`endif

  assign unusedWdBits = ^reg_wd[31:IRQ_NUM];

  assign rise      = lineSmp & ~histQ;
  assign active    = pendingQ & maskQ;
  assign anyActive = |active;

  always_comb begin
    w1c = '0;
    if (reg_we && (reg_addr == AddrPending)) begin
      w1c = reg_wd[IRQ_NUM-1:0];
    end
  end

  // Edge lines: a new rise beats a simultaneous clear. Level lines just follow the sample.
  assign pendingD = (modeQ & (rise | (pendingQ & ~w1c))) | (~modeQ & lineSmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      histQ    <= '0;
      pendingQ <= '0;
      maskQ    <= '0;
      modeQ    <= '0;
      irq_req  <= 1'b0;
    end else begin
      histQ    <= lineSmp;
      pendingQ <= pendingD;
      irq_req  <= anyActive;
      if (reg_we && (reg_addr == AddrMask)) begin
        maskQ <= reg_wd[IRQ_NUM-1:0];
      end
      if (reg_we && (reg_addr == AddrMode)) begin
        modeQ <= reg_wd[IRQ_NUM-1:0];
      end
    end
  end

  // Scan downwards so the lowest active index is the one left standing.
  always_comb begin
    idIdx = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (active[i]) begin
        idIdx = 5'(i);
      end
    end
  end

  always_comb begin
    reg_rd = '0;
    unique case (reg_addr)
      AddrPending: reg_rd[IRQ_NUM-1:0] = pendingQ;
      AddrMask:    reg_rd[IRQ_NUM-1:0] = maskQ;
      AddrMode:    reg_rd[IRQ_NUM-1:0] = modeQ;
      AddrId:      reg_rd = {anyActive, 26'd0, idIdx};
      default:     reg_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_sm_irq_ctrl.sv
// Directed self-checking bench for sm_irq_ctrl; latencies follow SM_CONFIG_IRQ_SYNC_EN.
module tb_sm_irq_ctrl;

`ifdef SM_CONFIG_IRQ_SYNC_EN
  localparam int Sync = 2;
`else
  localparam int Sync = 0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  irqIn;
  logic [1:0]  regAddr;
  logic        regWe;
  logic [31:0] regWd;
  logic [31:0] regRd;
  logic        irqReq;

  int nTests = 0;
  int nFail  = 0;

  sm_irq_ctrl #(.IRQ_NUM(8)) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .irq_in   (irqIn),
    .reg_addr (regAddr),
    .reg_we   (regWe),
    .reg_wd   (regWd),
    .reg_rd   (regRd),
    .irq_req  (irqReq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    regAddr = addr;
    regWd   = data;
    regWe   = 1'b1;
    tick();
    regWe   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] data);
    regAddr = addr;
    #1;
    data = regRd;
  endtask

  logic [31:0] v;
  int          firstRise;

  initial begin
    rstN    = 1'b0;
    irqIn   = 8'hFF;
    regAddr = 2'd0;
    regWe   = 1'b0;
    regWd   = 32'd0;

    // 1: reset with all lines high, MASK=0
    tickN(2);
    check("rst_irq_req", {31'd0, irqReq}, 32'd0);
    rstN = 1'b1;
    tickN(Sync + 1);
    rd(2'd0, v); check("rst_pending_level", v, 32'h0000_00FF);
    rd(2'd3, v); check("rst_id", v, 32'd0);
    rd(2'd1, v); check("rst_mask", v, 32'd0);
    check("rst_irq_masked", {31'd0, irqReq}, 32'd0);

    // 2: level line 2 high for 3 cycles
    irqIn = 8'h00;
    tickN(Sync + 2);
    wr(2'd1, 32'h0000_0004);
    rd(2'd1, v); check("mask_rd", v, 32'h0000_0004);
    check("t2_idle_irq", {31'd0, irqReq}, 32'd0);
    irqIn     = 8'h04;
    firstRise = -1;
    for (int c = 1; c <= Sync + 5; c++) begin
      tick();
      if (c == 3) irqIn = 8'h00;
      if (irqReq && firstRise < 0) firstRise = c;
      if (c == Sync + 1) begin
        rd(2'd0, v); check("t2_pending_set", v, 32'h0000_0004);
        check("t2_irq_lags", {31'd0, irqReq}, 32'd0);
      end
      if (c == Sync + 2) begin
        rd(2'd3, v); check("t2_id", v, 32'h8000_0002);
      end
      if (c == Sync + 4) begin
        check("t2_irq_last", {31'd0, irqReq}, 32'd1);
        rd(2'd0, v); check("t2_pending_clr", v, 32'd0);
      end
      if (c == Sync + 5) check("t2_irq_drop", {31'd0, irqReq}, 32'd0);
    end
    check("t2_irq_latency", 32'(firstRise), 32'(Sync + 2));

    // 3: edge line 0, single-cycle pulse, then W1C
    wr(2'd2, 32'h0000_0001);
    wr(2'd1, 32'h0000_0001);
    rd(2'd2, v); check("mode_rd", v, 32'h0000_0001);
    irqIn = 8'h01;
    tick();
    irqIn = 8'h00;
    tickN(Sync);
    rd(2'd0, v); check("t3_pending_edge", v, 32'h0000_0001);
    tick();
    check("t3_irq_set", {31'd0, irqReq}, 32'd1);
    tickN(3);
    rd(2'd0, v); check("t3_pending_hold", v, 32'h0000_0001);
    check("t3_irq_hold", {31'd0, irqReq}, 32'd1);
    wr(2'd0, 32'h0000_0001);
    rd(2'd0, v); check("t3_w1c", v, 32'd0);
    check("t3_irq_before_drop", {31'd0, irqReq}, 32'd1);
    tick();
    check("t3_irq_drop", {31'd0, irqReq}, 32'd0);

    // 4: W1C coincident with a fresh rise -> set wins
    irqIn = 8'h01;
    tick();
    irqIn = 8'h00;
    tickN(Sync + 1);
    rd(2'd0, v); check("t4_pending_pre", v, 32'h0000_0001);
    irqIn = 8'h01;
    tickN(Sync);
    wr(2'd0, 32'h0000_0001);
    rd(2'd0, v); check("t4_set_wins", v, 32'h0000_0001);
    wr(2'd0, 32'h0000_0001);
    rd(2'd0, v); check("t4_w1c_no_rise", v, 32'd0);
    irqIn = 8'h00;

    // 5: priority between lines 5 and 3
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, v); check("mask_upper_bits", v, 32'h0000_00FF);
    irqIn = 8'h28;
    tickN(Sync + 1);
    rd(2'd3, v); check("t5_id_3", v, 32'h8000_0003);
    irqIn = 8'h20;
    tickN(Sync + 1);
    rd(2'd3, v); check("t5_id_5", v, 32'h8000_0005);
    wr(2'd3, 32'h0000_0000);
    rd(2'd3, v); check("t5_id_ro", v, 32'h8000_0005);
    wr(2'd0, 32'h0000_0020);
    rd(2'd0, v); check("t5_level_w1c_ignored", v, 32'h0000_0020);
    check("t5_irq", {31'd0, irqReq}, 32'd1);

    // 6: asynchronous reset while the request is high
    #2;
    rstN = 1'b0;
    #1;
    check("t6_async_irq", {31'd0, irqReq}, 32'd0);
    rd(2'd1, v); check("t6_async_mask", v, 32'd0);
    rd(2'd0, v); check("t6_async_pending", v, 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
